// File: rtl/core_uart_apb_if.sv
// core_uart_apb_if: APB3 bus bundle (control, address, data, response) for the UART
interface core_uart_apb_if;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/core_uart_apb.sv
// core_uart_apb: APB3 UART, single-byte TX/RX buffers, 16x RX oversampling; `CORE_UART_BAUD_FRCTN_EN adds fractional baud
module core_uart_apb #(
  parameter int FIXEDMODE = 0,
  parameter int BAUD_VALUE = 1,
  parameter int PRG_BIT8 = 1,
  parameter int PRG_PARITY = 0,
  parameter int RX_LEGACY_MODE = 0,
  parameter int BAUD_VAL_FRCTN = 0
) (
  input  logic PCLK,
  input  logic PRESET,
  core_uart_apb_if.slave bus,
  output logic TXRDY,
  output logic RXRDY,
  output logic PARITY_ERR,
  output logic FRAMING_ERR,
  output logic OVERFLOW,
  input  logic RX,
  output logic TX
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} state_t;
  logic wr, rd, cfg_wr, tick, extra, bit8, par_en, odd;
  logic [12:0] baud, bcnt, baud_nxt;
  logic [2:0] frac;
  state_t tx_st, rx_st;
  logic [3:0] tx_cnt, rx_cnt;
  logic [2:0] tx_idx, rx_idx;
  logic [7:0] thr, tx_sh, rx_sh, rx_data, rx_byte;
  logic tx_par, tx_load, rx_s1, rx_s2, rx_q, rx_par, rx_stop, rx_mid, rx_end, rx_last, deliver, stop_bit;
  assign wr = bus.PSEL && bus.PENABLE && bus.PWRITE;
  assign rd = bus.PSEL && bus.PENABLE && !bus.PWRITE && bus.PADDR == 5'h04;
  assign cfg_wr = wr && FIXEDMODE == 0 && (bus.PADDR == 5'h08 || bus.PADDR == 5'h0C || bus.PADDR == 5'h14);
  assign baud_nxt = bus.PADDR == 5'h08 ? {baud[12:8], bus.PWDATA} :
                    bus.PADDR == 5'h0C ? {bus.PWDATA[7:3], baud[7:0]} : baud;
  assign bus.PREADY = 1'b1;
  assign bus.PSLVERR = 1'b0;
  assign bus.PRDATA = !(bus.PSEL && !bus.PWRITE) ? 8'h00 :
                      bus.PADDR == 5'h04 ? rx_data :
                      bus.PADDR == 5'h08 ? baud[7:0] :
                      bus.PADDR == 5'h0C ? {baud[12:8], odd, par_en, bit8} :
                      bus.PADDR == 5'h10 ? {3'b000, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY} :
                      bus.PADDR == 5'h14 ? {5'b00000, frac} : 8'h00;
  // runtime configuration; stays at the parameter values in fixed mode
  always_ff @(posedge PCLK)
    if (PRESET) begin
      baud <= 13'(BAUD_VALUE);
      bit8 <= PRG_BIT8 != 0;
      par_en <= PRG_PARITY != 0;
      odd <= PRG_PARITY == 2;
    end else if (cfg_wr) begin
      baud <= baud_nxt;
      if (bus.PADDR == 5'h0C) {odd, par_en, bit8} <= bus.PWDATA[2:0];
    end
`ifdef CORE_UART_BAUD_FRCTN_EN
  logic [2:0] fcnt;
  assign extra = fcnt < frac;
  // fraction register and tick position within each group of eight ticks
  always_ff @(posedge PCLK)
    if (PRESET) begin
      frac <= 3'(BAUD_VAL_FRCTN);
      fcnt <= '0;
    end else begin
      if (cfg_wr && bus.PADDR == 5'h14) frac <= bus.PWDATA[2:0];
      if (tick) fcnt <= fcnt + 3'd1;
    end
`else
  logic [2:0] unused_frac;
  assign unused_frac = 3'(BAUD_VAL_FRCTN);
  assign frac = '0;
  assign extra = 1'b0;
`endif
  assign tick = bcnt == '0;
  // 16x tick generator; a divisor rewrite restarts the period at once
  always_ff @(posedge PCLK)
    if (PRESET) bcnt <= '0;
    else bcnt <= cfg_wr ? baud_nxt : tick ? baud + 13'(extra) : bcnt - 13'd1;
  assign tx_load = !TXRDY && (tx_st == IDLE || (tx_st == STOP && tick && tx_cnt == 4'd15));
  // transmitter: holding reg feeds the shifter at the end of a stop bit so frames stream back to back
  always_ff @(posedge PCLK)
    if (PRESET) begin
      tx_st <= IDLE;
      TX <= 1'b1;
      TXRDY <= 1'b1;
      thr <= '0;
      tx_sh <= '0;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_par <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_st <= START;
        TX <= 1'b0;
        TXRDY <= 1'b1;
        tx_sh <= thr;
        tx_cnt <= '0;
        tx_idx <= '0;
        tx_par <= ^(bit8 ? thr : {1'b0, thr[6:0]}) ^ odd;
      end else if (tick) begin
        tx_cnt <= tx_cnt + 4'd1;
        if (tx_cnt == 4'd15)
          case (tx_st)
            START: begin
              tx_st <= DATA;
              TX <= tx_sh[0];
            end
            DATA: if (tx_idx == {2'b11, bit8}) begin
              tx_st <= par_en ? PARITY : STOP;
              TX <= par_en ? tx_par : 1'b1;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              tx_sh <= tx_sh >> 1;
              TX <= tx_sh[1];
            end
            PARITY: begin
              tx_st <= STOP;
              TX <= 1'b1;
            end
            default: tx_st <= IDLE;
          endcase
      end
      if (wr && bus.PADDR == 5'h00) begin
        thr <= bus.PWDATA;
        TXRDY <= 1'b0;
      end
    end
  assign rx_mid = tick && rx_cnt == 4'd7;
  assign rx_end = tick && rx_cnt == 4'd15;
  assign rx_last = rx_idx == {2'b11, bit8};
  assign rx_byte = bit8 ? rx_sh : {1'b0, rx_sh[7:1]};
  assign deliver = rx_st == STOP && (RX_LEGACY_MODE != 0 ? rx_end : rx_mid);
  assign stop_bit = RX_LEGACY_MODE != 0 ? rx_stop : rx_s2;
  // receiver: synchroniser, frame FSM and sticky flags; a flag set beats a same-cycle read-clear
  always_ff @(posedge PCLK)
    if (PRESET) begin
      {rx_s1, rx_s2, rx_q} <= 3'b111;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_par <= 1'b0;
      rx_stop <= 1'b0;
      rx_data <= '0;
      {RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR} <= '0;
    end else begin
      {rx_s1, rx_s2, rx_q} <= {RX, rx_s1, rx_s2};
      if (rd) {RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR} <= '0;
      if (tick) rx_cnt <= rx_cnt + 4'd1;
      case (rx_st)
        IDLE: if (rx_q && !rx_s2) begin
          rx_st <= START;
          rx_cnt <= '0;
        end
        START: if (rx_mid && rx_s2) rx_st <= IDLE;
          else if (rx_end) begin
            rx_st <= DATA;
            rx_idx <= '0;
          end
        DATA: begin
          if (rx_mid) rx_sh <= {rx_s2, rx_sh[7:1]};
          if (rx_end) begin
            rx_idx <= rx_idx + 3'd1;
            if (rx_last) rx_st <= par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (rx_mid) rx_par <= rx_s2;
          if (rx_end) rx_st <= STOP;
        end
        STOP: begin
          if (rx_mid) rx_stop <= rx_s2;
          if (deliver) begin
            if (!stop_bit) begin
              FRAMING_ERR <= 1'b1;
              rx_st <= WAIT;
            end else begin
              rx_st <= IDLE;
              if (RXRDY) OVERFLOW <= 1'b1;
              else begin
                rx_data <= rx_byte;
                RXRDY <= 1'b1;
                if (par_en && rx_par != (^rx_byte ^ odd)) PARITY_ERR <= 1'b1;
              end
            end
          end
        end
        WAIT: if (rx_s2) rx_st <= IDLE;
        default: rx_st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_core_uart_apb.sv
// tb_core_uart_apb: u1 transmits into u2, u3 runs in fixed mode; frames and flags checked against a byte-level model
module tb_core_uart_apb;
  logic clk = 1'b0, rst = 1'b1, rx_force = 1'b0;
  logic tx1, tx2, tx3;
  logic [4:0] f1, f2, f3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  core_uart_apb_if b1(), b2(), b3();
  core_uart_apb #(.BAUD_VALUE(1)) u1 (.PCLK(clk), .PRESET(rst), .bus(b1), .TXRDY(f1[0]), .RXRDY(f1[1]),
    .PARITY_ERR(f1[2]), .OVERFLOW(f1[3]), .FRAMING_ERR(f1[4]), .RX(1'b1), .TX(tx1));
  core_uart_apb #(.BAUD_VALUE(1)) u2 (.PCLK(clk), .PRESET(rst), .bus(b2), .TXRDY(f2[0]), .RXRDY(f2[1]),
    .PARITY_ERR(f2[2]), .OVERFLOW(f2[3]), .FRAMING_ERR(f2[4]), .RX(rx_force ? 1'b0 : tx1), .TX(tx2));
  core_uart_apb #(.FIXEDMODE(1), .BAUD_VALUE(1)) u3 (.PCLK(clk), .PRESET(rst), .bus(b3), .TXRDY(f3[0]), .RXRDY(f3[1]),
    .PARITY_ERR(f3[2]), .OVERFLOW(f3[3]), .FRAMING_ERR(f3[4]), .RX(1'b1), .TX(tx3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input int s, input logic sel, en, w, input logic [4:0] a, input logic [7:0] d);
    case (s)
      1: begin b1.PSEL = sel; b1.PENABLE = en; b1.PWRITE = w; b1.PADDR = a; b1.PWDATA = d; end
      2: begin b2.PSEL = sel; b2.PENABLE = en; b2.PWRITE = w; b2.PADDR = a; b2.PWDATA = d; end
      default: begin b3.PSEL = sel; b3.PENABLE = en; b3.PWRITE = w; b3.PADDR = a; b3.PWDATA = d; end
    endcase
  endtask

  task automatic apb(input int s, input logic w, input logic [4:0] a, input logic [7:0] d, output logic [7:0] q);
    clks(1);
    bus_set(s, 1'b1, 1'b0, w, a, d);
    clks(1);
    bus_set(s, 1'b1, 1'b1, w, a, d);
    q = s == 1 ? b1.PRDATA : s == 2 ? b2.PRDATA : b3.PRDATA;
    clks(1);
    bus_set(s, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
  endtask

  task automatic wr(input int s, input logic [4:0] a, input logic [7:0] d);
    logic [7:0] q;
    apb(s, 1'b1, a, d, q);
  endtask

  task automatic rd(input int s, input logic [4:0] a, output logic [7:0] q);
    apb(s, 1'b0, a, 8'h00, q);
  endtask

  task automatic cfg(input bit b8, pen, odd1, odd2);
    wr(1, 5'h0C, {5'b0, odd1, pen, b8});
    wr(2, 5'h0C, {5'b0, odd2, pen, b8});
  endtask

  // expected line: start 0, data LSB first, optional parity making the ones count even (or odd), stop 1
  task automatic send(input logic [7:0] d, input bit b8, pen, odd);
    logic bits[$];
    logic [7:0] v;
    int t;
    v = b8 ? d : {1'b0, d[6:0]};
    bits.push_back(1'b0);
    for (int i = 0; i < (b8 ? 8 : 7); i++) bits.push_back(v[i]);
    if (pen) bits.push_back(($countones(v) % 2 == 1) ^ odd);
    bits.push_back(1'b1);
    wr(1, 5'h00, d);
    t = 0;
    while (tx1 !== 1'b0 && t < 200) begin
      clks(1);
      t++;
    end
    check("tx_start_seen", 32'(t < 200), 1);
    clks(16);
    foreach (bits[i]) begin
      check($sformatf("tx_bit%0d", i), tx1, bits[i]);
      if (i < bits.size() - 1) clks(32);
    end
  endtask

  task automatic wait_rxrdy();
    int t = 0;
    while (f2[1] !== 1'b1 && t < 100) begin
      clks(1);
      t++;
    end
    check("rxrdy_set", f2[1], 1);
  endtask

  task automatic expect_rx(input logic [7:0] d, input bit b8, perr);
    logic [7:0] q;
    rd(2, 5'h10, q);
    check("rx_status", q, {5'b0, perr, 2'b11});
    rd(2, 5'h04, q);
    check("rx_data", q, b8 ? d : {1'b0, d[6:0]});
    rd(2, 5'h10, q);
    check("rx_cleared", q, 8'h01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    logic [7:0] d;
    bit b8, pen, o1, o2;
    int cnt;
    for (int s = 1; s <= 3; s++) bus_set(s, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    clks(5);
    rst = 1'b0;
    clks(2);
    check("reset_tx", tx1, 1);
    check("reset_flags", f1, 5'b00001);
    check("idle_prdata", b1.PRDATA, 0);
    rd(1, 5'h10, q); check("reset_status", q, 8'h01);
    rd(1, 5'h08, q); check("reset_ctrl1", q, 8'h01);
    rd(1, 5'h0C, q); check("reset_ctrl2", q, 8'h01);
    rd(1, 5'h14, q); check("reset_ctrl3", q, 8'h00);
    rd(1, 5'h18, q); check("unmapped", q, 8'h00);
    send(8'h55, 1, 0, 0);
    wait_rxrdy();
    expect_rx(8'h55, 1, 0);
    clks(20);
    cfg(1, 1, 0, 0);
    send(8'hA3, 1, 1, 0);
    wait_rxrdy();
    expect_rx(8'hA3, 1, 0);
    clks(20);
    cfg(1, 1, 0, 1);
    send(8'hA3, 1, 1, 0);
    wait_rxrdy();
    expect_rx(8'hA3, 1, 1);
    clks(20);
    cfg(1, 0, 0, 0);
    send(8'h11, 1, 0, 0);
    wait_rxrdy();
    send(8'h22, 1, 0, 0);
    clks(20);
    check("overflow_pin", f2[3], 1);
    rd(2, 5'h10, q); check("overflow_status", q, 8'h0B);
    rd(2, 5'h04, q); check("overflow_keeps_old", q, 8'h11);
    rd(2, 5'h10, q); check("overflow_cleared", q, 8'h01);
    clks(20);
    rx_force = 1'b1;
    clks(384);
    rx_force = 1'b0;
    clks(8);
    check("framing_err", f2[4], 1);
    check("framing_no_rxrdy", f2[1], 0);
    rd(2, 5'h04, q);
    check("framing_cleared", f2[4], 0);
    rx_force = 1'b1;
    clks(4);
    rx_force = 1'b0;
    clks(60);
    check("glitch_reject", f2, 5'b00001);
    wr(3, 5'h08, 8'h05);
    wr(3, 5'h0C, 8'h07);
    rd(3, 5'h08, q); check("fixed_ctrl1", q, 8'h01);
    rd(3, 5'h0C, q); check("fixed_ctrl2", q, 8'h01);
    wr(3, 5'h00, 8'h00);
    cnt = 0;
    while (tx3 !== 1'b0 && cnt < 200) begin
      clks(1);
      cnt++;
    end
    cnt = 0;
    while (tx3 === 1'b0 && cnt < 2000) begin
      clks(1);
      cnt++;
    end
    check("fixed_baud", 32'(cnt >= 285 && cnt <= 290), 1);
    wr(1, 5'h00, 8'h5A);
    clks(40);
    wr(1, 5'h00, 8'h00);
    rst = 1'b1;
    clks(1);
    check("midframe_reset_tx", tx1, 1);
    check("midframe_reset_flags", f1, 5'b00001);
    rst = 1'b0;
    clks(5);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      b8 = 1'($urandom);
      pen = 1'($urandom);
      o1 = 1'($urandom);
      o2 = 1'($urandom);
      cfg(b8, pen, o1, o2);
      send(d, b8, pen, o1);
      wait_rxrdy();
      expect_rx(d, b8, pen && (o1 != o2));
      clks(20);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
